// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the PC onto instruction memory and fills the
// IF/ID pipeline register. A one-word skid buffer catches a word that arrives
// while the decode side is stalled, so it is not lost and never fetched twice.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc_plus4,
  output logic [31:0] o_if_id_instr,
  output logic [5:0]  o_if_id_opcode,
  output logic [4:0]  o_if_id_rs,
  output logic [4:0]  o_if_id_rt,
  output logic [4:0]  o_if_id_rd,
  output logic [5:0]  o_if_id_funct,
  output logic [15:0] o_if_id_imm16
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_skid_instr;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;
  logic [31:0] r_if_instr;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_skid_next;
  logic        w_if_valid_next;
  logic [31:0] w_if_pc_next;
  logic [31:0] w_if_pc_plus4_next;
  logic [31:0] w_if_instr_next;
  logic [31:0] w_pc_plus4;
  logic        w_hold_pc;

  // Next-state selection: redirect beats everything, flush freezes PC/FSM like a
  // stall but still kills the IF/ID contents.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_skid_next        = r_skid_instr;
    w_if_valid_next    = r_if_valid;
    w_if_pc_next       = r_if_pc;
    w_if_pc_plus4_next = r_if_pc_plus4;
    w_if_instr_next    = r_if_instr;
    w_pc_plus4         = r_pc + 32'd4;
    w_hold_pc          = i_stall | i_flush;

    if (i_redirect_valid) begin
      w_pc_next          = i_redirect_pc & ~32'h0000_0003;
      w_state_next       = FETCH;
      w_skid_next        = 32'h0;
      w_if_valid_next    = 1'b0;
      w_if_pc_next       = 32'h0;
      w_if_pc_plus4_next = 32'h0;
      w_if_instr_next    = 32'h0;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (i_imem_valid) begin
            if (!w_hold_pc) begin
              w_if_valid_next    = 1'b1;
              w_if_pc_next       = r_pc;
              w_if_pc_plus4_next = w_pc_plus4;
              w_if_instr_next    = i_imem_rdata;
              w_pc_next          = w_pc_plus4;
            end else begin
              // Word arrived while decode is blocked: park it instead of refetching.
              w_skid_next  = i_imem_rdata;
              w_state_next = HOLD;
            end
          end else if (!w_hold_pc) begin
            w_if_valid_next    = 1'b0;
            w_if_pc_next       = 32'h0;
            w_if_pc_plus4_next = 32'h0;
            w_if_instr_next    = 32'h0;
          end
        end
        HOLD: begin
          if (!w_hold_pc) begin
            w_if_valid_next    = 1'b1;
            w_if_pc_next       = r_pc;
            w_if_pc_plus4_next = w_pc_plus4;
            w_if_instr_next    = r_skid_instr;
            w_pc_next          = w_pc_plus4;
            w_state_next       = FETCH;
          end
        end
        default: w_state_next = FETCH;
      endcase

      if (i_flush) begin
        w_if_valid_next    = 1'b0;
        w_if_pc_next       = 32'h0;
        w_if_pc_plus4_next = 32'h0;
        w_if_instr_next    = 32'h0;
      end
    end
  end

  // State registers with asynchronous clear to the reset PC and an empty IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_skid_instr  <= 32'h0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'h0;
      r_if_pc_plus4 <= 32'h0;
      r_if_instr    <= 32'h0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_skid_instr  <= w_skid_next;
      r_if_valid    <= w_if_valid_next;
      r_if_pc       <= w_if_pc_next;
      r_if_pc_plus4 <= w_if_pc_plus4_next;
      r_if_instr    <= w_if_instr_next;
    end
  end

  // Request is gated by rst_n so it drops immediately when reset asserts.
  assign o_imem_req       = (r_state == FETCH) && rst_n;
  assign o_imem_addr      = r_pc;
  assign o_if_id_valid    = r_if_valid;
  assign o_if_id_pc       = r_if_pc;
  assign o_if_id_pc_plus4 = r_if_pc_plus4;
  assign o_if_id_instr    = r_if_instr;

  // Decode field slices; a bubble (all-zero word) yields all-zero fields.
  assign o_if_id_opcode = r_if_instr[31:26];
  assign o_if_id_rs     = r_if_instr[25:21];
  assign o_if_id_rt     = r_if_instr[20:16];
  assign o_if_id_rd     = r_if_instr[15:11];
  assign o_if_id_funct  = r_if_instr[5:0];
  assign o_if_id_imm16  = r_if_instr[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// compared against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        req, ifv;
  logic [31:0] addr, ifpc, ifpc4, ifinstr;
  logic [5:0]  opc, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  logic        w_req, w_ifv;
  logic [31:0] w_addr, w_ifpc, w_ifpc4, w_ifinstr;
  logic [5:0]  w_opc, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (dut, RESET_PC = 0)
  logic [31:0] m_pc, m_skid, m_ipc, m_ipc4, m_instr;
  logic        m_hold, m_v;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_valid(imem_valid), .i_imem_rdata(imem_rdata),
    .i_stall(stall), .i_flush(flush),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_if_id_valid(ifv), .o_if_id_pc(ifpc), .o_if_id_pc_plus4(ifpc4),
    .o_if_id_instr(ifinstr), .o_if_id_opcode(opc), .o_if_id_rs(rs),
    .o_if_id_rt(rt), .o_if_id_rd(rd), .o_if_id_funct(funct), .o_if_id_imm16(imm)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(w_req), .o_imem_addr(w_addr),
    .i_imem_valid(imem_valid), .i_imem_rdata(imem_rdata),
    .i_stall(stall), .i_flush(flush),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_if_id_valid(w_ifv), .o_if_id_pc(w_ifpc), .o_if_id_pc_plus4(w_ifpc4),
    .o_if_id_instr(w_ifinstr), .o_if_id_opcode(w_opc), .o_if_id_rs(w_rs),
    .o_if_id_rt(w_rt), .o_if_id_rd(w_rd), .o_if_id_funct(w_funct), .o_if_id_imm16(w_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_bubble();
    m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = 32'h0;
  endtask

  task automatic model_issue(input logic [31:0] word);
    m_v = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = word; m_pc = m_pc + 32'd4;
  endtask

  // One clock edge of the fetch rules, applied to the inputs present at the edge.
  task automatic model_update();
    logic blocked;
    if (!rst_n) begin
      m_pc = 32'h0; m_hold = 1'b0; m_skid = 32'h0;
      model_bubble();
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00}; m_hold = 1'b0; m_skid = 32'h0;
      model_bubble();
    end else begin
      blocked = stall || flush;
      if (m_hold) begin
        if (!blocked) begin
          model_issue(m_skid);
          m_hold = 1'b0;
        end
      end else if (imem_valid) begin
        if (!blocked) model_issue(imem_rdata);
        else begin
          m_skid = imem_rdata; m_hold = 1'b1;
        end
      end else if (!blocked) begin
        model_bubble();
      end
      if (flush) model_bubble();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_valid = 1'b0; imem_rdata = 32'h0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", req); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=00000000", addr); end
    n_checks++; if ({ifv, ifpc, ifpc4, ifinstr} !== 97'h0) begin n_fail++; $display("FAIL reset_ifid got=%b/%h/%h/%h exp=all zero", ifv, ifpc, ifpc4, ifinstr); end
    n_checks++; if ({opc, rs, rt, rd, funct, imm} !== 43'h0) begin n_fail++; $display("FAIL reset_fields got=%h exp=0", {opc, rs, rt, rd, funct, imm}); end
    n_checks++; if (w_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_addr_wrap got=%h exp=fffffffc", w_addr); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL first_req got=%b/%h exp=1/00000000", req, addr); end
    $display("reset: req=%b addr=%h", req, addr);
  endtask

  task automatic test_wrap();
    logic [31:0] word;
    do_reset();
    word = $urandom;
    imem_valid = 1'b1; imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    n_checks++; if (w_ifpc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got=%h exp=fffffffc", w_ifpc); end
    n_checks++; if (w_ifpc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=00000000", w_ifpc4); end
    n_checks++; if (w_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got=%h exp=00000000", w_addr); end
    n_checks++; if (w_ifv !== 1'b1 || w_ifinstr !== word) begin n_fail++; $display("FAIL wrap_instr got=%b/%h exp=1/%h", w_ifv, w_ifinstr, word); end
    $display("wrap: ifpc=%h pc4=%h addr=%h", w_ifpc, w_ifpc4, w_addr);
  endtask

  task automatic test_stream();
    do_reset();
    imem_valid = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    n_checks++; if (ifv !== 1'b1 || ifpc !== 32'h0) begin n_fail++; $display("FAIL stream0_pc got=%b/%h exp=1/00000000", ifv, ifpc); end
    n_checks++; if (imm !== 16'h0005 || opc !== 6'd8 || rt !== 5'd8 || rs !== 5'd0) begin n_fail++; $display("FAIL stream0_fields got=imm %h opc %h rt %h rs %h exp=0005/08/08/00", imm, opc, rt, rs); end
    imem_rdata = 32'h2009_FFFF;
    tick();
    n_checks++; if (ifv !== 1'b1 || ifpc !== 32'h4 || ifpc4 !== 32'h8) begin n_fail++; $display("FAIL stream1_pc got=%b/%h/%h exp=1/00000004/00000008", ifv, ifpc, ifpc4); end
    n_checks++; if (imm !== 16'hFFFF || rt !== 5'd9 || rd !== 5'h1F || funct !== 6'h3F) begin n_fail++; $display("FAIL stream1_fields got=imm %h rt %h rd %h funct %h exp=ffff/09/1f/3f", imm, rt, rd, funct); end
    n_checks++; if (addr !== 32'h8) begin n_fail++; $display("FAIL stream_addr got=%h exp=00000008", addr); end
    $display("stream: ifpc=%h instr=%h addr=%h", ifpc, ifinstr, addr);
  endtask

  task automatic test_stall_data();
    logic [31:0] word;
    word = $urandom;
    imem_valid = 1'b1; imem_rdata = word; stall = 1'b1;
    tick();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL hold_req got=%b exp=0", req); end
    imem_rdata = ~word;
    tick();
    tick();
    n_checks++; if (req !== 1'b0 || addr !== 32'h8) begin n_fail++; $display("FAIL hold_pc got=%b/%h exp=0/00000008", req, addr); end
    n_checks++; if (ifv !== 1'b1 || ifpc !== 32'h4 || ifinstr !== 32'h2009_FFFF) begin n_fail++; $display("FAIL hold_ifid got=%b/%h/%h exp=1/00000004/2009ffff", ifv, ifpc, ifinstr); end
    stall = 1'b0; imem_valid = 1'b0;
    tick();
    n_checks++; if (ifv !== 1'b1 || ifpc !== 32'h8 || ifinstr !== word) begin n_fail++; $display("FAIL skid_issue got=%b/%h/%h exp=1/00000008/%h", ifv, ifpc, ifinstr, word); end
    n_checks++; if (addr !== 32'hC || req !== 1'b1) begin n_fail++; $display("FAIL skid_pc got=%b/%h exp=1/0000000c", req, addr); end
    $display("stall_data: ifpc=%h instr=%h addr=%h", ifpc, ifinstr, addr);
  endtask

  task automatic test_redirect_hold();
    logic [31:0] parked, fresh;
    parked = $urandom; fresh = $urandom;
    imem_valid = 1'b1; imem_rdata = parked; stall = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    n_checks++; if (addr !== 32'h40 || req !== 1'b1) begin n_fail++; $display("FAIL redir_addr got=%b/%h exp=1/00000040", req, addr); end
    n_checks++; if (ifv !== 1'b0 || ifinstr !== 32'h0) begin n_fail++; $display("FAIL redir_bubble got=%b/%h exp=0/00000000", ifv, ifinstr); end
    redirect_valid = 1'b0; stall = 1'b0; imem_valid = 1'b0;
    tick();
    n_checks++; if (ifv !== 1'b0 || addr !== 32'h40) begin n_fail++; $display("FAIL redir_noskid got=%b/%h exp=0/00000040", ifv, addr); end
    imem_valid = 1'b1; imem_rdata = fresh;
    tick();
    n_checks++; if (ifpc !== 32'h40 || ifinstr !== fresh) begin n_fail++; $display("FAIL redir_target got=%h/%h exp=00000040/%h", ifpc, ifinstr, fresh); end
    $display("redirect_hold: ifpc=%h instr=%h addr=%h", ifpc, ifinstr, addr);
  endtask

  task automatic test_wait_flush();
    imem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (ifv !== 1'b0 || ifinstr !== 32'h0 || addr !== 32'h44) begin n_fail++; $display("FAIL wait_bubble%0d got=%b/%h/%h exp=0/00000000/00000044", i, ifv, ifinstr, addr); end
    end
    imem_valid = 1'b1; imem_rdata = 32'h0123_4567;
    tick();
    imem_valid = 1'b0; flush = 1'b1; stall = 1'b1;
    tick();
    n_checks++; if (ifv !== 1'b0 || ifinstr !== 32'h0 || ifpc !== 32'h0) begin n_fail++; $display("FAIL flush_bubble got=%b/%h/%h exp=0/00000000/00000000", ifv, ifinstr, ifpc); end
    n_checks++; if (addr !== 32'h48) begin n_fail++; $display("FAIL flush_pc got=%h exp=00000048", addr); end
    flush = 1'b0; stall = 1'b0;
    $display("wait_flush: ifv=%b addr=%h", ifv, addr);
  endtask

  task automatic test_async_reset();
    imem_valid = 1'b1; imem_rdata = $urandom;
    tick();
    stall = 1'b1; imem_rdata = $urandom;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ifv !== 1'b0 || addr !== 32'h0 || req !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%b/%h/%b exp=0/00000000/0", ifv, addr, req); end
    tick();
    rst_n = 1'b1; stall = 1'b0; imem_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (ifv !== 1'b0 || ifinstr !== 32'h0 || addr !== 32'h0) begin n_fail++; $display("FAIL reset_skid got=%b/%h/%h exp=0/00000000/00000000", ifv, ifinstr, addr); end
    $display("async_reset: ifv=%b addr=%h", ifv, addr);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      imem_valid     = ($urandom_range(0, 9) < 7);
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      imem_rdata     = $urandom;
      tick();
      n_checks++; if (req !== !m_hold || addr !== m_pc) begin n_fail++; $display("FAIL rand_fetch c=%0d got=%b/%h exp=%b/%h", c, req, addr, !m_hold, m_pc); end
      n_checks++; if ({ifv, ifpc, ifpc4, ifinstr} !== {m_v, m_ipc, m_ipc4, m_instr}) begin n_fail++; $display("FAIL rand_ifid c=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", c, ifv, ifpc, ifpc4, ifinstr, m_v, m_ipc, m_ipc4, m_instr); end
      n_checks++; if ({opc, rs, rt, rd, funct, imm} !== {m_instr[31:26], m_instr[25:21], m_instr[20:16], m_instr[15:11], m_instr[5:0], m_instr[15:0]}) begin n_fail++; $display("FAIL rand_fields c=%0d instr=%h", c, ifinstr); end
      $display("rand c=%0d v=%b st=%b fl=%b rd=%b addr=%h ifv=%b ifpc=%h instr=%h", c, imem_valid, stall, flush, redirect_valid, addr, ifv, ifpc, ifinstr);
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    m_pc = 32'h0; m_hold = 1'b0; m_skid = 32'h0;
    model_bubble();
    test_reset();
    test_wrap();
    test_stream();
    test_stall_data();
    test_redirect_hold();
    test_wait_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request for address imem_addr.
REQ-005 imem_addr  output  32  fetch address, equal to the current PC register.
REQ-006 imem_valid  input  1  imem_rdata holds the word at imem_addr this cycle; meaningful only while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 stall  input  1  hazard unit: hold IF/ID and PC.
REQ-009 flush  input  1  insert bubble into IF/ID.
REQ-010 redirect_valid  input  1  branch/jump taken this cycle.
REQ-011 redirect_pc  input  32  target; bits [1:0] ignored (treated as 00).
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 if_id_pc, if_id_pc_plus4, if_id_instr  output  32 each  registered PC, PC+4, instruction.
REQ-014 if_id_opcode [31:26], if_id_rs [25:21], if_id_rt [20:16], if_id_rd [15:11], if_id_funct [5:0], if_id_imm16 [15:0]  output  6/5/5/5/6/16  combinational slices of if_id_instr; if_id_imm16 feeds the sign-extend unit.

Function
REQ-015 FSM states SHALL be FETCH and HOLD; skid register skid_instr (32) buffers one word.
REQ-016 imem_req SHALL be 1 in FETCH and 0 in HOLD and during reset.
REQ-017 Accept = FETCH && imem_valid && !stall && !redirect_valid: IF/ID <= {valid=1, pc, pc+4, imem_rdata}; PC <= PC+4; stay FETCH.
REQ-018 FETCH && imem_valid && stall && !redirect_valid: skid_instr <= imem_rdata; go HOLD; PC and IF/ID unchanged.
REQ-019 HOLD && !stall && !redirect_valid: IF/ID <= {1, PC, PC+4, skid_instr}; PC <= PC+4; go FETCH.
REQ-020 HOLD && stall: all state unchanged.
REQ-021 FETCH && !imem_valid && !stall: IF/ID <= bubble (valid=0, instr=0, pc fields 0); PC unchanged.
REQ-022 FETCH && !imem_valid && stall: IF/ID and PC unchanged.
REQ-023 redirect_valid=1 in any state SHALL override stall and imem_valid: PC <= {redirect_pc[31:2],2'b00}; state <= FETCH; skid discarded; IF/ID <= bubble; same-cycle imem_rdata discarded.
REQ-024 flush=1 without redirect SHALL force IF/ID <= bubble (overriding stall for IF/ID only); PC, FSM state and skid follow REQ-017..022 as if stall=1.
REQ-025 PC+4 SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no error.
REQ-026 Latency: an instruction accepted at edge N SHALL appear on if_id_* after edge N; throughput one instruction per cycle with imem_valid=1 and no stall.
REQ-027 Extracted field outputs SHALL be 0 whenever if_id_instr=0 (bubble encodes MIPS NOP).

Reset
REQ-028 While rst_n=0, immediately and independent of clk: PC=RESET_PC, state=FETCH, skid_instr=0, if_id_valid=0, all if_id_* = 0, imem_req=0.
REQ-029 First imem_req=1 SHALL occur in the cycle after rst_n deasserts, with imem_addr=RESET_PC.
REQ-030 rst_n asserted mid-HOLD SHALL discard the skid word; no instruction issued after release until newly fetched.

Verification
REQ-031 Streaming: reset release, imem_valid=1 every cycle, words 32'h2008_0005, 32'h2009_FFFF -> if_id_pc 0 then 4; if_id_imm16 16'h0005 then 16'hFFFF; if_id_valid=1 both cycles.
REQ-032 Stall with data: at PC=8, imem_valid=1, stall=1 for 3 cycles, then 0 -> imem_req=0 during HOLD, IF/ID unchanged, then if_id_pc=8 with buffered word, PC=12.
REQ-033 Redirect during HOLD with stall=1, redirect_pc=32'h0000_0043 -> next imem_addr=32'h0000_0040, if_id_valid=0, skid word never issued.
REQ-034 Wrap: RESET_PC=32'hFFFF_FFFC, imem_valid=1 -> if_id_pc=32'hFFFF_FFFC, if_id_pc_plus4=0, next imem_addr=0.
REQ-035 Memory wait + flush: imem_valid=0 two cycles -> two bubbles, PC held; flush=1 with stall=1 -> if_id_valid=0, if_id_instr=0, PC unchanged.
REQ-036 Async reset: rst_n low between clock edges while IF/ID valid -> if_id_valid=0 and imem_addr=RESET_PC before next clk edge.
